// File: rtl/calc_pkg.sv
// Shared definitions for the instruction-cache calculator and its program feeder.
// Contents: opcode constants, instruction width, feeder FSM state type, and the
// helper that decides which opcodes the optional prefilter drops.
package calc_pkg;

   localparam int unsigned INSTR_W = 7;

   localparam logic [2:0] OP_ADD    = 3'b000;
   localparam logic [2:0] OP_ADD2   = 3'b001;
   localparam logic [2:0] OP_FMA    = 3'b010;
   localparam logic [2:0] OP_RSVD   = 3'b011;
   localparam logic [2:0] OP_POPC   = 3'b100;
   localparam logic [2:0] OP_BREV   = 3'b101;
   localparam logic [2:0] OP_SETR   = 3'b110;
   localparam logic [2:0] OP_BUBBLE = 3'b111;

   typedef enum logic [2:0] {
      StIdle,
      StLoad,
      StDrain,
      StExec,
      StDone
   } feeder_state_t;

   // Opcodes the calculator always rejects; the prefilter replaces them with a bubble.
   function automatic logic is_reject_op(input logic [2:0] op);
      return (op == OP_RSVD) || (op == OP_BUBBLE);
   endfunction

endpackage

// File: rtl/calc_prog_mem.sv
// Program store for the calculator feeder.
// DEPTH x INSTR_W memory, synchronous write port, asynchronous read port, no reset.
// Ports: clk, we_i/waddr_i/wdata_i (write), raddr_i/rdata_o (combinational read).
module calc_prog_mem
   import calc_pkg::*;
#(
   parameter int unsigned DEPTH = 32,
   parameter int unsigned AW    = 5
) (
   input  logic               clk,
   input  logic               we_i,
   input  logic [AW-1:0]      waddr_i,
   input  logic [INSTR_W-1:0] wdata_i,
   input  logic [AW-1:0]      raddr_i,
   output logic [INSTR_W-1:0] rdata_o
);

   logic [INSTR_W-1:0] mem_q [DEPTH];

   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/calc_program_feeder.sv
// Upstream feeder for the 32-entry instruction-cache calculator.
// Holds a host-written program, streams it to the calculator in load mode, then
// drives execute mode for a programmable number of cycles, counting entries the
// calculator flagged invalid or dropped because its cache was full.
// Ports: clk/reset (async, active-high); host side prog_we/prog_addr/prog_data,
// prog_len/exec_cycles/start, busy/done; calculator side mode/opCode/value,
// cache_full_i/invalid_op_i; results invalid_cnt/dropped_cnt.
// Build option: define FEEDER_PREFILTER_EN to replace opcodes 011/111 in LOAD with a
// bubble and count them as invalid directly.
module calc_program_feeder
   import calc_pkg::*;
#(
   parameter int unsigned PROG_DEPTH = 32,
   parameter int unsigned AW         = 5,
   parameter int unsigned CW         = 8
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          prog_we,
   input  logic [AW-1:0] prog_addr,
   input  logic [6:0]    prog_data,
   input  logic [AW:0]   prog_len,
   input  logic [CW-1:0] exec_cycles,
   input  logic          start,
   output logic          busy,
   output logic          done,
   output logic          mode,
   output logic [2:0]    opCode,
   output logic [3:0]    value,
   input  logic          cache_full_i,
   input  logic          invalid_op_i,
   output logic [AW:0]   invalid_cnt,
   output logic [AW:0]   dropped_cnt
);

   localparam int unsigned LW = AW + 1;

   feeder_state_t      state_q;
   logic [AW-1:0]      ptr_q;
   logic [LW-1:0]      len_q;
   logic [CW-1:0]      cyc_q;
   logic [LW-1:0]      invalid_cnt_q;
   logic [LW-1:0]      dropped_cnt_q;
   logic [INSTR_W-1:0] rd_instr;

   logic          idle_like;
   logic          last_load;
   logic          filt_cur;
   logic          sample_flags;
   logic          inv_flag;
   logic          drop_flag;
   logic [LW-1:0] inv_inc;

   assign idle_like = (state_q == StIdle) || (state_q == StDone);

   calc_prog_mem #(
      .DEPTH (PROG_DEPTH),
      .AW    (AW)
   ) u_mem (
      .clk     (clk),
      .we_i    (prog_we && idle_like),
      .waddr_i (prog_addr),
      .wdata_i (prog_data),
      .raddr_i (ptr_q),
      .rdata_o (rd_instr)
   );

   assign last_load = ({1'b0, ptr_q} == (len_q - LW'(1)));

`ifdef FEEDER_PREFILTER_EN
   // Set when the previous LOAD slot was replaced by a bubble: its flags are not ours.
   logic prev_filt_q;

   assign filt_cur     = (state_q == StLoad) && is_reject_op(rd_instr[6:4]);
   assign sample_flags = ((state_q == StLoad && ptr_q != '0) || state_q == StDrain)
                         && !prev_filt_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         prev_filt_q <= 1'b0;
      end else if (idle_like) begin
         prev_filt_q <= 1'b0;
      end else if (state_q == StLoad) begin
         prev_filt_q <= filt_cur;
      end
   end
`else
   assign filt_cur     = 1'b0;
   assign sample_flags = (state_q == StLoad && ptr_q != '0) || (state_q == StDrain);
`endif

   // Flags lag the presented entry by one cycle; invalid takes priority over full.
   assign inv_flag  = sample_flags && invalid_op_i;
   assign drop_flag = sample_flags && !invalid_op_i && cache_full_i;
   assign inv_inc   = LW'(inv_flag) + LW'(filt_cur);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= StIdle;
         ptr_q         <= '0;
         len_q         <= '0;
         cyc_q         <= '0;
         invalid_cnt_q <= '0;
         dropped_cnt_q <= '0;
      end else begin
         unique case (state_q)
            StIdle, StDone: begin
               if (start) begin
                  len_q         <= prog_len;
                  cyc_q         <= exec_cycles;
                  ptr_q         <= '0;
                  invalid_cnt_q <= '0;
                  dropped_cnt_q <= '0;
                  if (prog_len != '0) begin
                     state_q <= StLoad;
                  end else if (exec_cycles != '0) begin
                     state_q <= StExec;
                  end else begin
                     state_q <= StDone;
                  end
               end
            end
            StLoad: begin
               ptr_q         <= ptr_q + AW'(1);
               invalid_cnt_q <= invalid_cnt_q + inv_inc;
               dropped_cnt_q <= dropped_cnt_q + LW'(drop_flag);
               if (last_load) begin
                  state_q <= StDrain;
               end
            end
            StDrain: begin
               invalid_cnt_q <= invalid_cnt_q + inv_inc;
               dropped_cnt_q <= dropped_cnt_q + LW'(drop_flag);
               state_q       <= (cyc_q != '0) ? StExec : StDone;
            end
            StExec: begin
               cyc_q <= cyc_q - CW'(1);
               if (cyc_q == CW'(1)) begin
                  state_q <= StDone;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   always_comb begin
      busy   = 1'b0;
      done   = 1'b0;
      mode   = 1'b0;
      opCode = OP_BUBBLE;
      value  = 4'd0;
      unique case (state_q)
         StLoad: begin
            busy = 1'b1;
            if (!filt_cur) begin
               {opCode, value} = rd_instr;
            end
         end
         StDrain: busy = 1'b1;
         StExec: begin
            busy   = 1'b1;
            mode   = 1'b1;
            opCode = 3'd0;
            value  = 4'd0;
         end
         StDone:  done = 1'b1;
         default: ;
      endcase
   end

   assign invalid_cnt = invalid_cnt_q;
   assign dropped_cnt = dropped_cnt_q;

endmodule

// File: doc/calc_program_feeder.md
Name: calc_program_feeder

Overview:
- Upstream stage of the 32-entry instruction-cache calculator.
- Holds a host-written program of up to 32 7-bit instructions ({opCode[2:0], value[3:0]}).
- On start, streams the program into the calculator's load interface (mode=0), then drives execute mode (mode=1) for a programmable number of cycles.
- Counts entries the calculator flagged as invalid or rejected because its cache was full.

Parameters:
- PROG_DEPTH, 32, program memory entries (power of two).
- AW, 5, program address width (log2 PROG_DEPTH).
- CW, 8, execute-cycle counter width.

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous, active-high reset
- prog_we  input  1  host write strobe; ignored while busy
- prog_addr  input  AW  host write address
- prog_data  input  7  host write data {opCode, value}
- prog_len  input  AW+1  entries to stream, 0..PROG_DEPTH; sampled on start
- exec_cycles  input  CW  execute-mode cycles to drive; sampled on start
- start  input  1  one-cycle request; ignored unless in IDLE or DONE
- busy  output  1  high in LOAD, DRAIN, EXEC
- done  output  1  high in DONE
- mode  output  1  to calculator: 0 = load, 1 = execute
- opCode  output  3  to calculator
- value  output  4  to calculator
- cache_full_i  input  1  calculator cacheFull (registered, one-cycle lag)
- invalid_op_i  input  1  calculator invalidOp (registered, one-cycle lag)
- invalid_cnt  output  AW+1  entries flagged invalidOp in last run
- dropped_cnt  output  AW+1  entries flagged cacheFull in last run

Behaviour:
- States: IDLE, LOAD, DRAIN, EXEC, DONE. The state register is the only control state.
- Reset (async) values:
  - state=IDLE, busy=0, done=0, mode=0, opCode=3'b111, value=0.
  - invalid_cnt=0, dropped_cnt=0, rd pointer=0.
  - Program memory is not cleared.
- IDLE/DONE:
  - Outputs are a bubble: mode=0, opCode=3'b111, value=0. The calculator rejects this as invalid and does not buffer it.
  - prog_we writes prog_data to mem[prog_addr] at the edge.
- start in IDLE/DONE:
  - Latch prog_len and exec_cycles.
  - Clear both counters and the pointer.
  - Next state is LOAD if prog_len>0, otherwise EXEC.
  - A write and start in the same cycle both take effect; the write lands first, so it is visible to the run.
- LOAD:
  - Outputs are combinational from mem[ptr]: mode=0, {opCode,value}=mem[ptr].
  - ptr increments each cycle. When ptr==len-1, next state is DRAIN.
  - Exactly len cycles; entry k is presented in LOAD cycle k.
- Flag accounting:
  - The calculator flags for entry k are visible in the cycle after it is presented. They are sampled at that cycle's closing edge.
  - Sampling is active in LOAD cycles 1..len-1 and in DRAIN.
  - invalid_op_i=1 → invalid_cnt+1.
  - Else cache_full_i=1 → dropped_cnt+1.
  - At most one increment per entry.
  - Flags seen during LOAD cycle 0 and during EXEC are ignored.
- DRAIN:
  - One cycle. Outputs the bubble so the last entry's flags are captured.
  - Next state is EXEC.
- EXEC:
  - mode=1; opCode and value are don't-care, driven 0.
  - Lasts exec_cycles cycles, then DONE. exec_cycles=0 skips directly to DONE with no mode=1 cycle.
- DONE:
  - done=1; counters hold until the next start.
- Write/start restrictions: prog_we is ignored while busy; start is ignored while busy.
- Reset mid-run returns to IDLE immediately. It does not clear the calculator, which shares the reset net.
- Counters cannot overflow: width AW+1, and each is at most prog_len.

Optional Feature:
- Macro: FEEDER_PREFILTER_EN.
- Defined:
  - In LOAD, entries whose opCode is 3'b011 or 3'b111 are not presented. That cycle outputs the bubble instead.
  - Each such entry adds 1 to invalid_cnt directly; calculator flags for that slot are ignored.
  - The cycle count is unchanged.
- Undefined: all entries are presented, and invalid_cnt comes only from invalid_op_i.

Decomposition:
- Shared package calc_pkg:
  - Opcode constants: OP_ADD=000, OP_ADD2=001, OP_FMA=010, OP_POPC=100, OP_BREV=101, OP_SETR=110, OP_BUBBLE=111.
  - Instruction width INSTR_W=7.
  - State enum typedef feeder_state_t.
- Sub-module calc_prog_mem: PROG_DEPTH x 7 memory with a synchronous write port and an asynchronous read port. Natural to split out.

Test Plan:
- Write 3 entries, ADD 5, ADD 3, ADD2 1; prog_len=3, exec_cycles=4; start.
  - Required: mode=0 for 4 cycles (3 LOAD + DRAIN), then mode=1 for 4 cycles, then done=1.
  - Calculator results 5, 8, 14, 19; invalid_cnt=0; dropped_cnt=0.
- Program with entry 1 = {011,2}, prog_len=3.
  - Undefined macro: invalid_cnt=1.
  - FEEDER_PREFILTER_EN: bubble on LOAD cycle 1 and invalid_cnt=1.
- Calculator pre-loaded with 30 entries; feed prog_len=4 → dropped_cnt=2, invalid_cnt=0.
- prog_len=0, exec_cycles=2 → LOAD and DRAIN skipped; mode=1 for exactly 2 cycles; done=1.
- Assert reset during LOAD cycle 2 → next sample: busy=0, done=0, mode=0, opCode=111, counters 0.
- start pulsed while busy, and prog_we while busy → both ignored; run timing and memory contents unchanged.
